// File: rtl/src_gen_pkg.sv
// Shared definitions for the source_gen2 test-data source: mode encodings,
// LFSR tap masks and default seeds.
package src_gen_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS = 2'd0,
    MODE_CNT  = 2'd1,
    MODE_PAT  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Feedback taps: x16 taps 15,13,12,10; x32 taps 31,21,1,0
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;
  localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;

  localparam logic [15:0] DEF_SEED16 = 16'hACE1;
  localparam logic [31:0] DEF_SEED32 = 32'hDEADBEEF;

  // Reserved encoding falls back to PRBS
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_CNT;
      2'd2:    return MODE_PAT;
      default: return MODE_PRBS;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_multistep.sv
// Fibonacci LFSR advanced STEPS times in one cycle. Each step emits the
// current MSB and shifts in the XOR of the tapped bits at the LSB.
// bits_o[STEPS-1] is the first bit produced.
module lfsr_multistep #(
  parameter int           W     = 16,
  parameter logic [W-1:0] TAPS  = '0,
  parameter int           STEPS = 8
) (
  input  logic [W-1:0]     state_i,
  output logic [W-1:0]     next_o,
  output logic [STEPS-1:0] bits_o
);

  logic [W-1:0] s_c;

  // Unrolled shift chain
  always_comb begin
    s_c    = state_i;
    bits_o = '0;
    for (int i = 0; i < STEPS; i++) begin
      bits_o[STEPS-1-i] = s_c[W-1];
      s_c = {s_c[W-2:0], ^(s_c & TAPS)};
    end
    next_o = s_c;
  end

endmodule

// File: rtl/source_gen2.sv
// AXI-Stream test-data source: PRBS (x16 ^ x32 LFSRs), counter ramp or fixed
// pattern, framed with tlast every FRAME_LEN beats.
// Optional macro SRC_SEED_LOAD_EN adds run-time LFSR reseeding ports.
module source_gen2
  import src_gen_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          FRAME_LEN = 8,
  parameter logic [15:0] SEED16    = DEF_SEED16,
  parameter logic [31:0] SEED32    = DEF_SEED32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic              m_tready,
`ifdef SRC_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [15:0]       seed16,
  input  logic [31:0]       seed32,
`endif
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic [15:0]       frame_cnt
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  logic [15:0]       lfsr16_q, lfsr16_d, l16_nxt;
  logic [31:0]       lfsr32_q, lfsr32_d, l32_nxt;
  logic [DATA_W-1:0] b16, b32;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  mode_e             mode_q, mode_d, cur_mode;
  logic [DATA_W-1:0] pat_q, pat_d, cur_pat;
  logic [DATA_W-1:0] tdata_q, tdata_d, word;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              seed_ld, load;

`ifdef SRC_SEED_LOAD_EN
  assign seed_ld = seed_load;
`else
  assign seed_ld = 1'b0;
`endif

  lfsr_multistep #(.W(16), .TAPS(LFSR16_TAPS), .STEPS(DATA_W)) u_l16 (
    .state_i (lfsr16_q),
    .next_o  (l16_nxt),
    .bits_o  (b16)
  );

  lfsr_multistep #(.W(32), .TAPS(LFSR32_TAPS), .STEPS(DATA_W)) u_l32 (
    .state_i (lfsr32_q),
    .next_o  (l32_nxt),
    .bits_o  (b32)
  );

  // Mode/pattern are only re-sampled at a frame boundary; the first beat of a
  // frame already uses the newly presented values.
  assign cur_mode = (beat_q == '0) ? decode_mode(mode) : mode_q;
  assign cur_pat  = (beat_q == '0) ? pattern : pat_q;

  // A reseed takes the cycle: it suppresses the load so no beat is built from
  // a half-updated generator state.
  assign load = enable && (!tvalid_q || m_tready) && !seed_ld;

  // Next-state: handshake retire, beat generation, optional reseed
  always_comb begin
    lfsr16_d = lfsr16_q;
    lfsr32_d = lfsr32_q;
    beat_d   = beat_q;
    ramp_d   = ramp_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    fcnt_d   = fcnt_q;
    word     = '0;

    if (tvalid_q && m_tready) begin
      tvalid_d = 1'b0;
      if (tlast_q) fcnt_d = fcnt_q + 16'd1;
    end

    if (load) begin
      if (beat_q == '0) begin
        mode_d = cur_mode;
        pat_d  = cur_pat;
      end
      case (cur_mode)
        MODE_CNT: begin
          word   = ramp_q;
          ramp_d = ramp_q + DATA_W'(1);
        end
        MODE_PAT: word = cur_pat;
        default: begin
          word     = b16 ^ b32;
          lfsr16_d = l16_nxt;
          lfsr32_d = l32_nxt;
        end
      endcase
      tdata_d  = word;
      tvalid_d = 1'b1;
      tlast_d  = (beat_q == LAST_BEAT);
      beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_W'(1);
    end

`ifdef SRC_SEED_LOAD_EN
    if (seed_load) begin
      lfsr16_d = (seed16 == '0) ? SEED16 : seed16;
      lfsr32_d = (seed32 == '0) ? SEED32 : seed32;
      beat_d   = '0;
      ramp_d   = '0;
    end
`endif
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lfsr16_q <= SEED16;
      lfsr32_q <= SEED32;
      beat_q   <= '0;
      ramp_q   <= '0;
      mode_q   <= MODE_PRBS;
      pat_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      lfsr16_q <= lfsr16_d;
      lfsr32_q <= lfsr32_d;
      beat_q   <= beat_d;
      ramp_q   <= ramp_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign m_tlast   = tlast_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_source_gen2.sv
// Scoreboard bench for source_gen2 (DATA_W=8, FRAME_LEN=8).
// Seed reload test is included when SRC_SEED_LOAD_EN is defined.
module tb_source_gen2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  pattern = 8'h00;
  logic        m_tready = 1'b1;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [15:0] frame_cnt;
`ifdef SRC_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed16 = 16'h0;
  logic [31:0] seed32 = 32'h0;
`endif

  source_gen2 dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .enable    (enable),
    .mode      (mode),
    .pattern   (pattern),
    .m_tready  (m_tready),
`ifdef SRC_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed16    (seed16),
    .seed32    (seed32),
`endif
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .frame_cnt (frame_cnt)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [15:0] f;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got[$];
  logic [7:0] ref_run[$];

  // Bit-serial reference model
  logic [15:0] m16;
  logic [31:0] m32;
  logic [7:0]  mramp, mpat;
  logic [1:0]  mmode;
  int          mbeat;
  logic [15:0] mframes;

  task automatic model_reset();
    m16 = 16'hACE1; m32 = 32'hDEADBEEF;
    mramp = 8'h00; mpat = 8'h00; mmode = 2'd0; mbeat = 0; mframes = 16'h0;
  endtask

  task automatic model_push(input logic [1:0] md, input logic [7:0] pat);
    exp_t e;
    logic [7:0] w;
    logic b, f16, f32;
    w = 8'h00;
    if (mbeat == 0) begin mmode = md; mpat = pat; end
    if (mmode == 2'd1) begin
      w = mramp; mramp = mramp + 8'd1;
    end else if (mmode == 2'd2) begin
      w = mpat;
    end else begin
      for (int i = 0; i < 8; i++) begin
        b   = m16[15] ^ m32[31];
        w   = {w[6:0], b};
        f16 = m16[15] ^ m16[13] ^ m16[12] ^ m16[10];
        f32 = m32[31] ^ m32[21] ^ m32[1] ^ m32[0];
        m16 = {m16[14:0], f16};
        m32 = {m32[30:0], f32};
      end
    end
    e.d = w; e.l = (mbeat == 7); e.f = mframes;
    exp_q.push_back(e);
    if (mbeat == 7) begin mframes = mframes + 16'd1; mbeat = 0; end
    else mbeat = mbeat + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold under stall
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h0;
  logic       prev_l = 1'b0;
  exp_t       me;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l) begin
          errors++;
          $display("FAIL hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   m_tvalid, m_tdata, m_tlast, prev_d, prev_l);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%0h with empty scoreboard", m_tdata);
        end else begin
          me = exp_q.pop_front();
          if (m_tdata !== me.d || m_tlast !== me.l || frame_cnt !== me.f) begin
            errors++;
            $display("FAIL beat: got d=%0h l=%0b fc=%0d expected d=%0h l=%0b fc=%0d",
                     m_tdata, m_tlast, frame_cnt, me.d, me.l, me.f);
          end
        end
        got.push_back(m_tdata);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Issue n loads in the given mode, then idle until the stream drains
  task automatic run_phase(input int n, input logic [1:0] md, input logic [7:0] pat, input bit bp);
    int loads = 0;
    int cyc = 0;
    for (int i = 0; i < n; i++) model_push(md, pat);
    mode = md; pattern = pat;
    while ((loads < n || exp_q.size() != 0 || m_tvalid) && cyc < n * 6 + 40) begin
      @(posedge aclk); #2;
      cyc++;
      m_tready = (bp && loads < n) ? 1'($urandom_range(0, 1)) : 1'b1;
      enable   = (loads < n);
      if (enable && (!m_tvalid || m_tready)) loads++;
    end
    enable = 1'b0;
    checks++;
    if (loads < n || exp_q.size() != 0 || m_tvalid) begin
      errors++;
      $display("FAIL phase_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge aclk); #2;
    aresetn = 1'b0; enable = 1'b0; m_tready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_tdata", 32'(m_tdata), 32'h0);
    chk("rst_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_tlast", 32'(m_tlast), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    model_reset();
    got.delete();
    @(posedge aclk); #2;
    aresetn = 1'b1;
  endtask

  initial begin
    int diff;
    model_reset();
    repeat (2) @(posedge aclk);

    // Free-running PRBS
    do_reset();
    run_phase(64, 2'd0, 8'h00, 1'b0);
    chk("prbs_beat0", 32'(got[0]), 32'h72);
    chk("prbs_beat1", 32'(got[1]), 32'h4C);
    ref_run = got;

    // Same stream under random backpressure
    do_reset();
    run_phase(64, 2'd0, 8'h00, 1'b1);
    diff = 0;
    for (int i = 0; i < 64; i++) if (got.size() <= i || got[i] !== ref_run[i]) diff++;
    chk("bp_stream_diffs", 32'(diff), 32'h0);

    // Mode switch mid-frame, then back to PRBS; enable drops between phases
    do_reset();
    run_phase(3, 2'd0, 8'h00, 1'b0);
    run_phase(13, 2'd2, 8'hA5, 1'b0);
    run_phase(8, 2'd0, 8'h00, 1'b0);
    chk("sw_prbs_tail", 32'(got[7]), 32'(ref_run[7]));
    chk("sw_pattern", 32'(got[8]), 32'hA5);
    chk("sw_pattern_end", 32'(got[15]), 32'hA5);
    diff = 0;
    for (int i = 0; i < 8; i++) if (got[16+i] !== ref_run[8+i]) diff++;
    chk("sw_prbs_resume_diffs", 32'(diff), 32'h0);
    run_phase(8, 2'd3, 8'h00, 1'b0);

    // Reset mid-frame with a beat held under backpressure
    do_reset();
    run_phase(11, 2'd0, 8'h00, 1'b0);
    @(posedge aclk); #2;
    enable = 1'b1; m_tready = 1'b0;
    @(posedge aclk); #1;
    chk("held_valid", 32'(m_tvalid), 32'h1);
    do_reset();
    run_phase(10, 2'd0, 8'h00, 1'b0);
    chk("rst_restart_beat0", 32'(got[0]), 32'h72);

    // Counter ramp with wrap
    do_reset();
    run_phase(300, 2'd1, 8'h00, 1'b0);
    chk("ramp_first", 32'(got[0]), 32'h00);
    chk("ramp_ff", 32'(got[255]), 32'hFF);
    chk("ramp_wrap", 32'(got[256]), 32'h00);
    chk("ramp_frames", 32'(frame_cnt), 32'd37);

`ifdef SRC_SEED_LOAD_EN
    // Reseed with zero seeds falls back to the parameter seeds
    do_reset();
    run_phase(5, 2'd0, 8'h00, 1'b0);
    @(posedge aclk); #2;
    seed16 = 16'h0; seed32 = 32'h0; seed_load = 1'b1;
    @(posedge aclk); #2;
    seed_load = 1'b0;
    m16 = 16'hACE1; m32 = 32'hDEADBEEF; mbeat = 0; mramp = 8'h00;
    run_phase(8, 2'd0, 8'h00, 1'b0);
    chk("seed_reload_beat", 32'(got[5]), 32'h72);
`endif

    repeat (3) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
